// File: rtl/lut_delay_tap_ctrl.sv
// ---------------------------------------------------------------------------
// lut_delay_tap_ctrl
//
// Multi-channel LUT delay-line tap controller. Each channel owns a saturating
// tap counter (0..TAPS) and a registered thermometer-coded select bus that
// enables the first tap[c] LUT stages of that channel's delay line. Commands
// arrive on an IDELAY-style rst/ce/inc interface. Each accepted command
// opens a settle window (busy) and ends with a one-cycle done pulse.
//
// Ports
//   clk         in   system clock, single domain
//   rst         in   synchronous active-high reset
//   idelay_rst  in   reload targeted channel(s) to INIT_TAP (beats idelay_ce)
//   idelay_ce   in   step targeted channel(s) by one tap
//   idelay_inc  in   step direction: 1 = +1 tap, 0 = -1 tap
//   ch_sel      in   target channel index
//   ch_all      in   target every channel (overrides ch_sel)
//   sel_signal  out  thermometer select, channel c at [c*TAPS +: TAPS]
//   tap_count   out  tap value, channel c at [c*TAP_W +: TAP_W]
//   busy        out  settle window active; commands are dropped
//   done        out  one-cycle completion pulse
//   nochange    out  qualified by done: no targeted tap changed value
// ---------------------------------------------------------------------------
module lut_delay_tap_ctrl #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CH_W     = 1,
  parameter int unsigned TAPS     = 8,
  parameter int unsigned TAP_W    = 4,
  parameter int unsigned INIT_TAP = 0,
  parameter int unsigned SETTLE   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      idelay_rst,
  input  logic                      idelay_ce,
  input  logic                      idelay_inc,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic                      ch_all,
  output logic [CHANNELS*TAPS-1:0]  sel_signal,
  output logic [CHANNELS*TAP_W-1:0] tap_count,
  output logic                      busy,
  output logic                      done,
  output logic                      nochange
);

  // Settle counter needs to reach SETTLE-1; keep at least one bit so the
  // register still exists when SETTLE is 0 or 1.
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TAP_W-1:0] TapInit = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TapMax  = TAP_W'(TAPS);

  // Thermometer code: bit i set iff i < tap.
  function automatic logic [TAPS-1:0] f_therm(input logic [TAP_W-1:0] tap);
    logic [TAPS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      t[i] = (i < 32'(tap));
    end
    return t;
  endfunction

  localparam logic [TAPS-1:0] ThermInit = f_therm(TapInit);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDone
  } state_e;

  // With no settle window the command goes straight to its done cycle.
  localparam state_e StAfterCmd = (SETTLE == 0) ? StDone : StSettle;

  // Declaration initialisers give power-up values identical to reset.
  state_e                         r_state    = StIdle;
  state_e                         w_state_nxt;
  logic [CntW-1:0]                r_cnt      = '0;
  logic [CHANNELS-1:0][TAP_W-1:0] r_tap      = {CHANNELS{TapInit}};
  logic [CHANNELS-1:0][TAPS-1:0]  r_sel      = {CHANNELS{ThermInit}};
  logic                           r_nochange = 1'b0;

  logic                           w_cmd;
  logic                           w_accept;
  logic [CHANNELS-1:0]            w_target;
  logic [CHANNELS-1:0][TAP_W-1:0] w_tap_nxt;
  logic                           w_changed;

  // ---------------------------------------------------------------------
  // Command acceptance
  // ---------------------------------------------------------------------
  // The done cycle behaves like idle, so only the settle window drops work.
  always_comb begin
    w_cmd    = idelay_rst | idelay_ce;
    w_accept = w_cmd & (r_state != StSettle);
  end

  // Out-of-range ch_sel matches no channel index, giving an empty target set.
  always_comb begin
    w_target = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_target[c] = ch_all | (32'(ch_sel) == c);
    end
  end

  // Candidate next taps for the presented command, plus whether any of them
  // would move. Applied only when the command is accepted.
  always_comb begin
    w_tap_nxt = r_tap;
    w_changed = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_target[c]) begin
        if (idelay_rst) begin
          w_tap_nxt[c] = TapInit;
        end else if (idelay_ce) begin
          if (idelay_inc) begin
            if (r_tap[c] < TapMax) begin
              w_tap_nxt[c] = r_tap[c] + 1'b1;
            end
          end else if (r_tap[c] != '0) begin
            w_tap_nxt[c] = r_tap[c] - 1'b1;
          end
        end
      end
      w_changed = w_changed | (w_tap_nxt[c] != r_tap[c]);
    end
  end

  // ---------------------------------------------------------------------
  // Tap and select registers (updated on the accepting edge)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap      <= {CHANNELS{TapInit}};
      r_sel      <= {CHANNELS{ThermInit}};
      r_nochange <= 1'b0;
    end else if (w_accept) begin
      r_tap      <= w_tap_nxt;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_sel[c] <= f_therm(w_tap_nxt[c]);
      end
      r_nochange <= ~w_changed;
    end
  end

  // ---------------------------------------------------------------------
  // Settle counter: counts 0..SETTLE-1 while in StSettle
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == StSettle) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_cmd) begin
          w_state_nxt = StAfterCmd;
        end
      end
      StSettle: begin
        if (r_cnt == CntLast) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = w_cmd ? StAfterCmd : StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (r_state == StSettle);
    done     = (r_state == StDone);
    nochange = (r_state == StDone) & r_nochange;
  end

  always_comb begin
    sel_signal = r_sel;
    tap_count  = r_tap;
  end

endmodule

// File: tb/tb_lut_delay_tap_ctrl.sv
// Directed bench for lut_delay_tap_ctrl. Three instances:
//   0: defaults (2 channels, 8 taps, SETTLE=3)
//   1: SETTLE=0
//   2: CHANNELS=1 (ch_sel=1 is out of range)
module tb_lut_delay_tap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v  = '1;
  logic [2:0] irst_v = '0;
  logic [2:0] ce_v   = '0;
  logic [2:0] inc_v  = '0;
  logic [2:0] chs_v  = '0;
  logic [2:0] all_v  = '0;

  logic [15:0] sel0, sel1;
  logic [7:0]  tap0, tap1;
  logic [7:0]  sel2;
  logic [3:0]  tap2;
  logic [2:0]  busy_v, done_v, nc_v;

  int n_cmp  = 0;
  int n_fail = 0;

  lut_delay_tap_ctrl dut (
    .clk(clk), .rst(rst_v[0]), .idelay_rst(irst_v[0]), .idelay_ce(ce_v[0]),
    .idelay_inc(inc_v[0]), .ch_sel(chs_v[0]), .ch_all(all_v[0]),
    .sel_signal(sel0), .tap_count(tap0), .busy(busy_v[0]), .done(done_v[0]),
    .nochange(nc_v[0])
  );

  lut_delay_tap_ctrl #(.SETTLE(0)) dut_s0 (
    .clk(clk), .rst(rst_v[1]), .idelay_rst(irst_v[1]), .idelay_ce(ce_v[1]),
    .idelay_inc(inc_v[1]), .ch_sel(chs_v[1]), .ch_all(all_v[1]),
    .sel_signal(sel1), .tap_count(tap1), .busy(busy_v[1]), .done(done_v[1]),
    .nochange(nc_v[1])
  );

  lut_delay_tap_ctrl #(.CHANNELS(1), .CH_W(1)) dut_c1 (
    .clk(clk), .rst(rst_v[2]), .idelay_rst(irst_v[2]), .idelay_ce(ce_v[2]),
    .idelay_inc(inc_v[2]), .ch_sel(chs_v[2]), .ch_all(all_v[2]),
    .sel_signal(sel2), .tap_count(tap2), .busy(busy_v[2]), .done(done_v[2]),
    .nochange(nc_v[2])
  );

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input bit r, input bit c, input bit i,
                       input bit s, input bit a);
    irst_v[w] = r;
    ce_v[w]   = c;
    inc_v[w]  = i;
    chs_v[w]  = s;
    all_v[w]  = a;
  endtask

  // Present one command for one cycle, then wait (bounded) for done.
  task automatic issue(input int w, input bit r, input bit c, input bit i,
                       input bit s, input bit a,
                       output int nbusy, output bit got, output bit nc);
    drive(w, r, c, i, s, a);
    step();
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nbusy = 0;
    got   = 1'b0;
    nc    = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done_v[w]) begin
        got = 1'b1;
        nc  = nc_v[w];
      end else begin
        if (busy_v[w]) nbusy++;
        step();
      end
    end
    if (got) step();
  endtask

  task automatic test_reset();
    rst_v = '1;
    step();
    step();
    rst_v = '0;
    n_cmp++; if (sel0 !== 16'h0000) begin n_fail++; $display("FAIL reset_sel got %h want %h", sel0, 16'h0000); end
    n_cmp++; if (tap0 !== 8'h00) begin n_fail++; $display("FAIL reset_tap got %h want %h", tap0, 8'h00); end
    n_cmp++; if (busy_v !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b want 000", busy_v); end
    n_cmp++; if (done_v !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b want 000", done_v); end
    n_cmp++; if (nc_v !== 3'b000) begin n_fail++; $display("FAIL reset_nochange got %b want 000", nc_v); end
  endtask

  task automatic test_inc();
    int nb; bit got; bit nc;
    // Observe the accepting edge directly.
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (tap0 !== 8'h10) begin n_fail++; $display("FAIL inc_tap_e0 got %h want %h", tap0, 8'h10); end
    n_cmp++; if (sel0 !== 16'h0100) begin n_fail++; $display("FAIL inc_sel_e0 got %h want %h", sel0, 16'h0100); end
    nb = 0; got = 1'b0; nc = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done_v[0]) begin got = 1'b1; nc = nc_v[0]; end
      else begin if (busy_v[0]) nb++; step(); end
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL inc_done got 0 want 1"); end
    n_cmp++; if (nb != 3) begin n_fail++; $display("FAIL inc_busy_cycles got %0d want 3", nb); end
    n_cmp++; if (nc !== 1'b0) begin n_fail++; $display("FAIL inc_nochange got %b want 0", nc); end
    if (got) step();
    n_cmp++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL inc_done_pulse got %b want 0", done_v[0]); end
  endtask

  task automatic test_saturate();
    int nb; bit got; bit nc;
    for (int k = 0; k < 7; k++) begin
      issue(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, nb, got, nc);
      n_cmp++; if (!got || nc !== 1'b0) begin n_fail++; $display("FAIL sat_step%0d got done=%b nc=%b want done=1 nc=0", k, got, nc); end
    end
    n_cmp++; if (tap0 !== 8'h80) begin n_fail++; $display("FAIL sat_tap got %h want %h", tap0, 8'h80); end
    n_cmp++; if (sel0 !== 16'hFF00) begin n_fail++; $display("FAIL sat_sel got %h want %h", sel0, 16'hFF00); end
    issue(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, nb, got, nc);
    n_cmp++; if (!got || nc !== 1'b1) begin n_fail++; $display("FAIL sat_top_nc got done=%b nc=%b want done=1 nc=1", got, nc); end
    n_cmp++; if (sel0 !== 16'hFF00) begin n_fail++; $display("FAIL sat_top_sel got %h want %h", sel0, 16'hFF00); end
    issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, nb, got, nc);
    n_cmp++; if (!got || nc !== 1'b1) begin n_fail++; $display("FAIL sat_bot_nc got done=%b nc=%b want done=1 nc=1", got, nc); end
    n_cmp++; if (tap0 !== 8'h80) begin n_fail++; $display("FAIL sat_bot_tap got %h want %h", tap0, 8'h80); end
  endtask

  task automatic test_all();
    int nb; bit got; bit nc;
    issue(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nb, got, nc);
    issue(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nb, got, nc);
    n_cmp++; if (tap0 !== 8'h82) begin n_fail++; $display("FAIL all_pre_tap got %h want %h", tap0, 8'h82); end
    issue(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, nb, got, nc);
    n_cmp++; if (tap0 !== 8'h83) begin n_fail++; $display("FAIL all_inc_tap got %h want %h", tap0, 8'h83); end
    n_cmp++; if (sel0 !== 16'hFF07) begin n_fail++; $display("FAIL all_inc_sel got %h want %h", sel0, 16'hFF07); end
    n_cmp++; if (!got || nc !== 1'b0) begin n_fail++; $display("FAIL all_inc_nc got done=%b nc=%b want done=1 nc=0", got, nc); end
    // rst and ce together: rst wins.
    issue(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, nb, got, nc);
    n_cmp++; if (tap0 !== 8'h00) begin n_fail++; $display("FAIL all_rst_tap got %h want %h", tap0, 8'h00); end
    n_cmp++; if (sel0 !== 16'h0000) begin n_fail++; $display("FAIL all_rst_sel got %h want %h", sel0, 16'h0000); end
    n_cmp++; if (!got || nc !== 1'b0) begin n_fail++; $display("FAIL all_rst_nc got done=%b nc=%b want done=1 nc=0", got, nc); end
    issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, nb, got, nc);
    n_cmp++; if (!got || nc !== 1'b1) begin n_fail++; $display("FAIL all_rst_again_nc got done=%b nc=%b want done=1 nc=1", got, nc); end
  endtask

  task automatic test_back_to_back();
    bit got;
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();                                  // accepted, busy cycle 1
    step();                                  // ce seen in busy cycle 1
    step();                                  // ce seen in busy cycle 2
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (done_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", done_v[0]); end
    n_cmp++; if (tap0 !== 8'h01) begin n_fail++; $display("FAIL b2b_drop_tap got %h want %h", tap0, 8'h01); end
    n_cmp++; if (sel0 !== 16'h0001) begin n_fail++; $display("FAIL b2b_drop_sel got %h want %h", sel0, 16'h0001); end
    // Command presented in the done cycle is taken.
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy_v[0]); end
    n_cmp++; if (tap0 !== 8'h02) begin n_fail++; $display("FAIL b2b_accept_tap got %h want %h", tap0, 8'h02); end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (done_v[0]) got = 1'b1; else step();
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL b2b_second_done got 0 want 1"); end
    step();
  endtask

  task automatic test_abort();
    bit seen;
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (tap0 !== 8'h12) begin n_fail++; $display("FAIL abort_pre_tap got %h want %h", tap0, 8'h12); end
    step();                                  // busy cycle 2
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    n_cmp++; if (tap0 !== 8'h00) begin n_fail++; $display("FAIL abort_tap got %h want %h", tap0, 8'h00); end
    n_cmp++; if (sel0 !== 16'h0000) begin n_fail++; $display("FAIL abort_sel got %h want %h", sel0, 16'h0000); end
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy_v[0]); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done_v[0] || busy_v[0]) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL abort_no_done got 1 want 0"); end
  endtask

  task automatic test_settle0();
    drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    n_cmp++; if (done_v[1] !== 1'b1) begin n_fail++; $display("FAIL s0_done got %b want 1", done_v[1]); end
    n_cmp++; if (busy_v[1] !== 1'b0) begin n_fail++; $display("FAIL s0_busy got %b want 0", busy_v[1]); end
    n_cmp++; if (tap1 !== 8'h01 || nc_v[1] !== 1'b0) begin n_fail++; $display("FAIL s0_tap got tap=%h nc=%b want tap=01 nc=0", tap1, nc_v[1]); end
    step();                                  // ce still high in done cycle
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (done_v[1] !== 1'b1 || tap1 !== 8'h02) begin n_fail++; $display("FAIL s0_b2b got done=%b tap=%h want done=1 tap=02", done_v[1], tap1); end
    n_cmp++; if (sel1 !== 16'h0003) begin n_fail++; $display("FAIL s0_sel got %h want %h", sel1, 16'h0003); end
    step();
    n_cmp++; if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin n_fail++; $display("FAIL s0_idle got done=%b busy=%b want 0 0", done_v[1], busy_v[1]); end
  endtask

  task automatic test_ch_oob();
    int nb; bit got; bit nc;
    issue(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, nb, got, nc);
    n_cmp++; if (!got || nc !== 1'b1) begin n_fail++; $display("FAIL oob_nc got done=%b nc=%b want done=1 nc=1", got, nc); end
    n_cmp++; if (tap2 !== 4'h0 || sel2 !== 8'h00) begin n_fail++; $display("FAIL oob_tap got tap=%h sel=%h want 0 00", tap2, sel2); end
    issue(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, nb, got, nc);
    n_cmp++; if (!got || nc !== 1'b0 || nb != 3) begin n_fail++; $display("FAIL c1_inc got done=%b nc=%b busy=%0d want 1 0 3", got, nc, nb); end
    n_cmp++; if (tap2 !== 4'h1 || sel2 !== 8'h01) begin n_fail++; $display("FAIL c1_tap got tap=%h sel=%h want 1 01", tap2, sel2); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_saturate();
    test_all();
    test_back_to_back();
    test_abort();
    test_settle0();
    test_ch_oob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
